// File: rtl/pico_fifo_pkg.sv
// -----------------------------------------------------------------------------
// pico_fifo_pkg
// Shared helpers for the PicoBus FIFO slice:
//   - clog2()        : ceiling log2 for sizing counters from a word count
//   - count_w()      : width of an occupancy counter that must reach DEPTH
//   - par_w()        : physical port width of the sideband bus (>= 1)
//   - af/ae range    : legal ranges for the almost-full / almost-empty offsets
// -----------------------------------------------------------------------------
package pico_fifo_pkg;

    localparam int DEPTH_LOG2_MIN = 1;
    localparam int DEPTH_LOG2_MAX = 24;
    localparam int AF_OFFSET_MIN  = 1;
    localparam int AE_OFFSET_MIN  = 0;

    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Occupancy runs 0..DEPTH inclusive, so one more state than the pointers.
    function automatic int count_w(input int depth_log2);
        return clog2((1 << depth_log2) + 1);
    endfunction

    // A zero-width sideband still needs a 1-bit port to stay legal.
    function automatic int par_w(input int par_width);
        return (par_width > 0) ? par_width : 1;
    endfunction

    function automatic bit af_in_range(input int depth_log2, input int af_offset);
        return (af_offset >= AF_OFFSET_MIN) && (af_offset <= (1 << depth_log2) - 1);
    endfunction

    function automatic bit ae_in_range(input int depth_log2, input int ae_offset);
        return (ae_offset >= AE_OFFSET_MIN) && (ae_offset <= (1 << depth_log2) - 2);
    endfunction

endpackage

// File: rtl/pico_sdp_ram.sv
// -----------------------------------------------------------------------------
// pico_sdp_ram
// Simple-dual-port RAM written in the canonical block-RAM template:
// one synchronous write port, one read port with a single registered output.
// Ports:
//   clk, rst        clock; synchronous active-high reset (output register only)
//   we/waddr/wdata  write port
//   re/raddr        read request; data appears on rdata after the next edge
//   rdata           registered read data, holds its value when re is low
// -----------------------------------------------------------------------------
module pico_sdp_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [0:(1 << ADDR_W)-1];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the storage array has no reset; resetting it would prevent block
    // RAM inference, and the FIFO never reads a location it has not written.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // The output register maps onto the RAM primitive's own output latch,
    // which supports a synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO: block RAM storage plus a two-slot
// prefetch (the RAM read register and a fabric output register).
// Optional build macro: SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   din, dinp, wr_en    write data, sideband, request (accepted iff !full)
//   rd_en               acknowledge head word (accepted iff !empty)
//   dout, doutp         head word and its sideband, valid while !empty
//   full, empty         registered exact flags
//   prog_full           count >= DEPTH - ALMOST_FULL_OFFSET
//   prog_empty          count <= ALMOST_EMPTY_OFFSET
//   count               words accepted and not yet read
//   overflow, underflow sticky error flags (macro builds only)
// -----------------------------------------------------------------------------
module sync_fifo_fwft
    import pico_fifo_pkg::*;
#(
    parameter int DATA_WIDTH          = 128,
    parameter int PAR_WIDTH           = 16,
    parameter int DEPTH_LOG2          = 9,
    parameter int ALMOST_FULL_OFFSET  = 16,
    parameter int ALMOST_EMPTY_OFFSET = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic [par_w(PAR_WIDTH)-1:0]      dinp,
    input  logic                             wr_en,
    input  logic                             rd_en,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic [par_w(PAR_WIDTH)-1:0]      doutp,
    output logic                             full,
    output logic                             empty,
    output logic                             prog_full,
    output logic                             prog_empty,
    output logic [count_w(DEPTH_LOG2)-1:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                             overflow,
    output logic                             underflow
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = count_w(DEPTH_LOG2);
    localparam int RAM_W = DATA_WIDTH + PAR_WIDTH;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - ALMOST_FULL_OFFSET);
    localparam logic [CW-1:0] AE_LEVEL = CW'(ALMOST_EMPTY_OFFSET);

    // ------------------------------------------------------------ elaboration
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("sync_fifo_fwft: DATA_WIDTH must be >= 1");
    end
    if (PAR_WIDTH < 0) begin : g_bad_par_width
        $error("sync_fifo_fwft: PAR_WIDTH must be >= 0");
    end
    if (DEPTH_LOG2 < DEPTH_LOG2_MIN || DEPTH_LOG2 > DEPTH_LOG2_MAX) begin : g_bad_depth
        $error("sync_fifo_fwft: DEPTH_LOG2 out of range");
    end
    if (!af_in_range(DEPTH_LOG2, ALMOST_FULL_OFFSET)) begin : g_bad_af
        $error("sync_fifo_fwft: ALMOST_FULL_OFFSET must be 1..DEPTH-1");
    end
    if (!ae_in_range(DEPTH_LOG2, ALMOST_EMPTY_OFFSET)) begin : g_bad_ae
        $error("sync_fifo_fwft: ALMOST_EMPTY_OFFSET must be 0..DEPTH-2");
    end

    // ------------------------------------------------------------ state
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  prog_full_q, prog_full_d;
    logic                  prog_empty_q, prog_empty_d;
    logic                  inflight_q, inflight_d;    // RAM read register holds an unread word
    logic                  out_valid_q, out_valid_d;  // fabric register holds the head word
    logic [RAM_W-1:0]      out_q, out_d;

    logic                  wr_acc, rd_acc, issue, move;
    logic [CW-1:0]         ram_words;
    logic [1:0]            held;
    logic [RAM_W-1:0]      wr_word, ram_rdata, head;

    if (PAR_WIDTH > 0) begin : g_par
        assign wr_word = {dinp, din};
        assign doutp   = head[RAM_W-1:DATA_WIDTH];
    end else begin : g_no_par
        assign wr_word = din;
        assign doutp   = '0;
    end

    pico_sdp_ram #(
        .WIDTH  (RAM_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr_q),
        .wdata (wr_word),
        .re    (issue),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    // The fabric register only ever holds a word older than the one in the
    // RAM read register, so it takes priority as the head.
    assign head = out_valid_q ? out_q : ram_rdata;
    assign dout = head[DATA_WIDTH-1:0];

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        wr_acc      = wr_en && !full_q;
        rd_acc      = rd_en && !empty_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        inflight_d  = inflight_q;
        count_d     = count_q;

        // Words still sitting in RAM, not yet read into either prefetch slot.
        ram_words = count_q - CW'(out_valid_q) - CW'(inflight_q);
        // Prefetch slots still occupied after this cycle's read.
        held      = 2'(out_valid_q) + 2'(inflight_q) - 2'(rd_acc);
        issue     = (ram_words != '0) && (held != 2'd2);
        // A new RAM read overwrites the read register; if its word is still
        // unread it must first be parked in the fabric register.
        move      = issue && inflight_q && !(rd_acc && !out_valid_q);

        if (move) begin
            out_valid_d = 1'b1;
            out_d       = ram_rdata;
        end else if (rd_acc && out_valid_q) begin
            out_valid_d = 1'b0;
        end

        if (issue) begin
            inflight_d = 1'b1;
        end else if (rd_acc && !out_valid_q) begin
            inflight_d = 1'b0;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        wptr_d       = wptr_q + DEPTH_LOG2'(wr_acc);
        rptr_d       = rptr_q + DEPTH_LOG2'(issue);
        full_d       = (count_d == DEPTH_C);
        empty_d      = !(out_valid_d || inflight_d);
        prog_full_d  = (count_d >= AF_LEVEL);
        prog_empty_d = (count_d <= AE_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
            inflight_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            prog_full_q  <= prog_full_d;
            prog_empty_q <= prog_empty_d;
            inflight_q   <= inflight_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
        end
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign prog_full  = prog_full_q;
    assign prog_empty = prog_empty_q;
    assign count      = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (wr_en && full_q);
        underflow_d = underflow_q || (rd_en && empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
